// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire layer.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam logic RST_ZERO = 1'b0;
  localparam logic RST_SUB  = 1'b1;

  localparam int SHIFT_W = 3;

endpackage

// File: rtl/lif_update.sv
// Single-channel LIF datapath, purely combinational; time-shared across channels.
// Leak by shift, saturating integrate, threshold fire, reset and refractory bookkeeping.
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int REFRAC_W = 4
) (
  input  logic [WIDTH-1:0]    mem,
  input  logic [WIDTH-1:0]    current,
  input  logic [REFRAC_W-1:0] refrac_cnt,
  input  logic [WIDTH-1:0]    threshold,
  input  logic [SHIFT_W-1:0]  decay_shift,
  input  logic                reset_mode,
  input  logic [REFRAC_W-1:0] refrac_period,
  output logic [WIDTH-1:0]    mem_next,
  output logic                spike,
  output logic [REFRAC_W-1:0] refrac_next
);

  logic [WIDTH-1:0] leaked;
  logic [WIDTH-1:0] eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sum_sat;
  logic             refractory;

  // A shift of zero removes the whole membrane, giving a full leak.
  assign leaked     = mem - (mem >> decay_shift);
  assign refractory = (refrac_cnt != '0);
  assign eff        = refractory ? '0 : current;
  assign sum        = {1'b0, leaked} + {1'b0, eff};
  assign sum_sat    = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  assign spike      = !refractory && (sum_sat >= threshold);

  always_comb begin
    mem_next    = sum_sat;
    refrac_next = refractory ? (refrac_cnt - REFRAC_W'(1)) : '0;
    if (spike) begin
      refrac_next = refrac_period;
      case (reset_mode)
        RST_ZERO: mem_next = '0;
        RST_SUB:  mem_next = sum_sat - threshold;
        default:  mem_next = '0;
      endcase
    end
  end

endmodule

// File: rtl/lif_layer.sv
// Layer of CHANNELS LIF neurons, one channel per cycle; result CHANNELS+1 cycles after accept, held until out_ready.
// Refractory counters exist only when LIF_REFRACTORY_EN is defined; otherwise refrac_period is ignored.
module lif_layer
  import lif_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int REFRAC_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_current,
  input  logic [WIDTH-1:0]          threshold,
  input  logic [SHIFT_W-1:0]        decay_shift,
  input  logic                      reset_mode,
  input  logic [REFRAC_W-1:0]       refrac_period,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       out_spikes,
  output logic [CHANNELS*WIDTH-1:0] out_mem
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [CHANNELS*WIDTH-1:0] cur_q;
  logic [WIDTH-1:0]          thr_q;
  logic [SHIFT_W-1:0]        k_q;
  logic                      mode_q;
  logic [WIDTH-1:0]          mem [CHANNELS];
  logic [CHANNELS-1:0]       spk_acc;

  logic [WIDTH-1:0]          mem_next;
  logic                      spike;
  logic [REFRAC_W-1:0]       cnt_sel;
  logic [REFRAC_W-1:0]       per_sel;
  logic [REFRAC_W-1:0]       refrac_next;
  logic [CHANNELS*WIDTH-1:0] mem_view;
  logic [CHANNELS-1:0]       spk_view;

`ifdef LIF_REFRACTORY_EN
  logic [REFRAC_W-1:0] per_q;
  logic [REFRAC_W-1:0] refrac [CHANNELS];

  assign cnt_sel = refrac[idx];
  assign per_sel = per_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q <= '0;
      for (int i = 0; i < CHANNELS; i++) refrac[i] <= '0;
    end else begin
      if (state == IDLE && in_valid && in_ready) per_q <= refrac_period;
      if (state == UPDATE) refrac[idx] <= refrac_next;
    end
  end
`else
  logic unused_refrac;

  assign cnt_sel       = '0;
  assign per_sel       = '0;
  assign unused_refrac = ^{refrac_period, refrac_next};
`endif

  lif_update #(
    .WIDTH    (WIDTH),
    .REFRAC_W (REFRAC_W)
  ) u_update (
    .mem           (mem[idx]),
    .current       (cur_q[idx*WIDTH +: WIDTH]),
    .refrac_cnt    (cnt_sel),
    .threshold     (thr_q),
    .decay_shift   (k_q),
    .reset_mode    (mode_q),
    .refrac_period (per_sel),
    .mem_next      (mem_next),
    .spike         (spike),
    .refrac_next   (refrac_next)
  );

  // Full post-update view including the channel being written this cycle.
  always_comb begin
    mem_view = '0;
    spk_view = spk_acc;
    for (int i = 0; i < CHANNELS; i++) mem_view[i*WIDTH +: WIDTH] = mem[i];
    mem_view[idx*WIDTH +: WIDTH] = mem_next;
    spk_view[idx] = spike;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_spikes <= '0;
      out_mem    <= '0;
      idx        <= '0;
      cur_q      <= '0;
      thr_q      <= '0;
      k_q        <= '0;
      mode_q     <= RST_ZERO;
      spk_acc    <= '0;
      for (int i = 0; i < CHANNELS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cur_q    <= in_current;
            thr_q    <= threshold;
            k_q      <= decay_shift;
            mode_q   <= reset_mode;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          mem[idx]     <= mem_next;
          spk_acc[idx] <= spike;
          idx          <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            idx        <= '0;
            out_mem    <= mem_view;
            out_spikes <= spk_view;
            out_valid  <= 1'b1;
            state      <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lif_layer.md
Name: lif_layer

Overview:
- Parametrised successor to the single 8-bit recurrent neuron: a layer of CHANNELS leaky integrate-and-fire neurons with per-channel membrane state, shift-based leak, threshold spiking, selectable reset mode and refractory period.
- One time step is processed per accepted input vector. Channels are updated one per cycle through a shared datapath.
- Sits between the input-current encoder and the spike consumer, with valid/ready on both sides.

Parameters:
- WIDTH, 8, bits per input current and per membrane potential (unsigned).
- CHANNELS, 4, number of neurons; must be ≥1.
- REFRAC_W, 4, bit width of the refractory counter and of refrac_period.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  input vector valid.
- in_ready  output  1  layer can accept a time step.
- in_current  input  CHANNELS*WIDTH  per-channel current; channel i is at bits [i*WIDTH +: WIDTH].
- threshold  input  WIDTH  firing threshold.
- decay_shift  input  3  leak shift k.
- reset_mode  input  1  0 = reset to zero, 1 = subtract threshold.
- refrac_period  input  REFRAC_W  refractory time steps after a spike.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_spikes  output  CHANNELS  spike per channel for this step.
- out_mem  output  CHANNELS*WIDTH  post-update membrane potentials.

Behaviour:
- Clocking and reset: one clock domain, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values:
  - FSM = IDLE, in_ready = 1, out_valid = 0.
  - out_spikes = 0, out_mem = 0.
  - All membranes = 0, all refractory counters = 0, channel index = 0.
  - Reset mid-step aborts the step; no partial result is ever presented.
- FSM states: IDLE, UPDATE, OUTPUT.
  - IDLE: in_ready = 1. On in_valid & in_ready, capture in_current, threshold, decay_shift, reset_mode and refrac_period, then go to UPDATE with idx = 0. Config is held constant for the whole step.
  - UPDATE: in_ready = 0. Update channel idx each cycle. After idx = CHANNELS-1, go to OUTPUT.
  - OUTPUT: out_valid = 1, and out_spikes/out_mem are stable. On out_ready, go to IDLE.
- Latency: handshake in cycle 0 → out_valid in cycle CHANNELS+1. Throughput is one step per CHANNELS+2 cycles when out_ready is held high.
- No combinational paths: neither in_ready nor out_valid depends combinationally on in_valid or out_ready.
- Per-channel update (unsigned, WIDTH bits):
  - leaked = mem - (mem >> k). k = 0 gives full leak, leaked = 0.
  - eff = (refrac_cnt != 0) ? 0 : current.
  - sum = leaked + eff, computed in WIDTH+1 bits and saturated to 2^WIDTH-1.
  - spike = (refrac_cnt == 0) && (sum >= threshold). threshold = 0 therefore fires on every non-refractory step.
  - On spike: mem_next = reset_mode ? sum - threshold : 0, and refrac_cnt = refrac_period.
  - Otherwise: mem_next = sum, and refrac_cnt decrements if nonzero.
  - out_mem[i] = mem_next and out_spikes[i] = spike. Both are registered and held until the next OUTPUT.
- Boundaries:
  - in_valid during UPDATE or OUTPUT is ignored; the source must hold it.
  - out_ready low holds OUTPUT indefinitely.
  - refrac_period = 0 means no refractory behaviour.

Optional Feature:
- Macro: LIF_REFRACTORY_EN.
- Defined: refractory counters and the behaviour above are implemented.
- Undefined: no counters are instantiated; refrac_period is accepted but ignored; refrac_cnt is treated as constant 0. Every step integrates and may spike.

Decomposition:
- Package lif_pkg:
  - FSM state enum (IDLE, UPDATE, OUTPUT).
  - Reset-mode constants RST_ZERO = 0, RST_SUB = 1.
  - Width of decay_shift (3).
- Sub-module lif_update: combinational single-channel datapath. Inputs are mem, current, refrac_cnt and config; outputs are mem_next, spike and refrac_next. It is instantiated once and time-shared.

Test Plan (WIDTH = 8, CHANNELS = 4, macro defined unless noted):
- Reset: assert rst_n = 0 asynchronously mid-UPDATE → in_ready = 1, out_valid = 0, out_mem = 0 immediately; the next step starts from mem = 0.
- Integrate and fire: threshold = 100, k = 7, reset_mode = 0, ch0 current = 30 for 4 steps → mem 30, 60, 90, then spike with mem = 0; out_valid rises 5 cycles after each handshake.
- Leak: k = 1, ch1 current 80 then 0, 0, with threshold = 255 → mem 80, 40, 20, no spikes.
- Saturation and subtract: k = 7, threshold = 250, reset_mode = 1, ch2 current 200 twice → step 1 mem 200, no spike; step 2 sum = 199 + 200 saturates to 255, spike, mem = 5.
- Backpressure: out_ready = 0 for 5 cycles in OUTPUT → out_valid held, outputs stable, in_ready = 0, extra in_valid ignored. Release → IDLE next cycle.
- Refractory: refrac_period = 2, threshold = 10, k = 7, ch3 current 20 every step → spike at steps 1 and 4; steps 2 and 3 show no spike and mem = 0. With the macro undefined, ch3 spikes every step.
